// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game controller: state encoding,
// score width and a saturating score increment.
package pong_pkg;

  localparam int STATE_W = 3;
  localparam int SCORE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? lim : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_tick_div.sv
// Frame-tick divider: emits one pulse every div_i ticks; held at zero while clear_i.
module pong_tick_div
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic [SCORE_W-1:0] div_i,
  input  logic               tick_i,
  output logic               pulse_o
);

  logic [SCORE_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a divisor shrinking mid-count still fires promptly
  assign pulse_o = tick_i && !clear_i && (cnt_q >= div_i - SCORE_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (tick_i) cnt_d = pulse_o ? '0 : cnt_q + SCORE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing FSM: serve delay, ball step pacing, scoring and game over.
// Define SPEEDUP_EN to shorten the ball step period every 4 paddle hits.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int BASE_DIV     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               paddle_collision,
  output logic               ball_reset,
  output logic               move_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [STATE_W-1:0] state,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] BASE = SCORE_W'(BASE_DIV);
  localparam int                 SW   = $clog2(SERVE_FRAMES + 1);
  localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_FRAMES - 1);

  state_e             state_q;
  logic [SCORE_W-1:0] score_l_q, score_r_q, div_q;
  logic               serve_dir_q, winner_q, step;
  logic [SW-1:0]      serve_cnt_q;

  wire in_play  = (state_q == ST_PLAY);
  wire miss_any = miss_left | miss_right;

  pong_tick_div u_div (
    .clk    (clk),
    .rst_n  (reset),
    .clear_i(!in_play),
    .div_i  (div_q),
    .tick_i (frame_tick),
    .pulse_o(step)
  );

  assign move_en    = step & ~miss_any;
  assign ball_reset = !in_play;
  assign serve_dir  = serve_dir_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign state      = state_q;
  assign winner     = winner_q;

`ifdef SPEEDUP_EN
  logic [1:0] coll_q;

  // Divisor sits at BASE throughout SERVE, so every rally starts at base speed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= BASE;
      coll_q <= '0;
    end else if (state_q == ST_SERVE) begin
      div_q  <= BASE;
      coll_q <= '0;
    end else if (in_play && paddle_collision) begin
      coll_q <= coll_q + 2'd1;
      if (coll_q == 2'd3 && div_q > SCORE_W'(1)) div_q <= div_q - SCORE_W'(1);
    end
  end
`else
  logic unused_coll;
  assign div_q       = BASE;
  assign unused_coll = paddle_collision;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b1;
      winner_q    <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_dir_q <= 1'b1;
            serve_cnt_q <= '0;
            state_q     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            serve_cnt_q <= serve_cnt_q + SW'(1);
            if (serve_cnt_q == SERVE_LAST) state_q <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (miss_left && !miss_right) begin
            score_r_q   <= sat_inc(score_r_q, WIN);
            serve_dir_q <= 1'b0;
            state_q     <= ST_POINT;
          end else if (miss_right && !miss_left) begin
            score_l_q   <= sat_inc(score_l_q, WIN);
            serve_dir_q <= 1'b1;
            state_q     <= ST_POINT;
          end else if (miss_left && miss_right) begin
            state_q <= ST_POINT;
          end
        end
        ST_POINT: begin
          if (score_l_q == WIN) begin
            winner_q <= 1'b0;
            state_q  <= ST_GAME_OVER;
          end else if (score_r_q == WIN) begin
            winner_q <= 1'b1;
            state_q  <= ST_GAME_OVER;
          end else begin
            serve_cnt_q <= '0;
            state_q     <= ST_SERVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Table-driven bench for pong_game_ctrl (WIN_SCORE=3, SERVE_FRAMES=2, BASE_DIV=2).
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0;
  logic       miss_left = 1'b0, miss_right = 1'b0, paddle_collision = 1'b0;
  logic       ball_reset, move_en, serve_dir, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(2), .BASE_DIV(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .start           (start),
    .miss_left       (miss_left),
    .miss_right      (miss_right),
    .paddle_collision(paddle_collision),
    .ball_reset      (ball_reset),
    .move_en         (move_en),
    .serve_dir       (serve_dir),
    .score_l         (score_l),
    .score_r         (score_r),
    .state           (state),
    .winner          (winner)
  );

  typedef struct {
    logic       r, ft, st, ml, mr, pc;
    logic [2:0] s;
    logic       br, me;
    logic [3:0] sl, sr;
    logic       sd, w;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic ft, logic st, logic ml, logic mr, logic pc,
                              logic [2:0] s, logic br, logic me, logic [3:0] sl,
                              logic [3:0] sr, logic sd, logic w);
    vec_t v;
    v.r = r; v.ft = ft; v.st = st; v.ml = ml; v.mr = mr; v.pc = pc;
    v.s = s; v.br = br; v.me = me; v.sl = sl; v.sr = sr; v.sd = sd; v.w = w;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic ft, input logic st,
                       input logic ml, input logic mr, input logic pc);
    @(negedge clk);
    reset = r; frame_tick = ft; start = st;
    miss_left = ml; miss_right = mr; paddle_collision = pc;
    #1;
  endtask

  initial begin
    //        r ft st ml mr pc | s br me sl sr sd w
    vt.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0,1,0));
    vt.push_back(mk(1,0,1,0,0,0, 0,1,0,0,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 2,0,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,1,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,1,0,0,1,0));
    vt.push_back(mk(1,0,0,0,1,0, 2,0,0,0,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 3,1,0,1,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 1,1,0,1,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,0,1,0,1,0));
    vt.push_back(mk(1,1,0,1,0,0, 2,0,0,1,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 3,1,0,1,1,0,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,1,0,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,1,0,0));
    vt.push_back(mk(1,0,0,1,1,1, 2,0,0,1,1,0,0));
    vt.push_back(mk(1,0,0,1,0,0, 3,1,0,1,1,0,0));
    vt.push_back(mk(1,0,0,0,1,0, 1,1,0,1,1,0,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,1,0,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,1,0,0));
    vt.push_back(mk(1,0,0,1,0,0, 2,0,0,1,1,0,0));
    vt.push_back(mk(1,0,0,0,0,0, 3,1,0,1,2,0,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,2,0,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,1,2,0,0));
    vt.push_back(mk(1,0,0,1,0,0, 2,0,0,1,2,0,0));
    vt.push_back(mk(1,0,0,0,0,0, 3,1,0,1,3,0,0));
    vt.push_back(mk(1,0,0,1,0,0, 4,1,0,1,3,0,1));
    vt.push_back(mk(1,1,0,0,1,0, 4,1,0,1,3,0,1));
    vt.push_back(mk(1,0,1,0,0,0, 4,1,0,1,3,0,1));
    vt.push_back(mk(1,0,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,0,0,0,1,0));
    vt.push_back(mk(0,1,0,0,0,0, 0,1,0,0,0,1,0));
    vt.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0,1,0));
    vt.push_back(mk(1,0,1,0,0,0, 0,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,0, 2,0,1,0,0,1,0));

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].ft, vt[i].st, vt[i].ml, vt[i].mr, vt[i].pc);
      chk($sformatf("v%0d state", i),      state,      vt[i].s);
      chk($sformatf("v%0d ball_reset", i), ball_reset, vt[i].br);
      chk($sformatf("v%0d move_en", i),    move_en,    vt[i].me);
      chk($sformatf("v%0d score_l", i),    score_l,    vt[i].sl);
      chk($sformatf("v%0d score_r", i),    score_r,    vt[i].sr);
      chk($sformatf("v%0d serve_dir", i),  serve_dir,  vt[i].sd);
      if (vt[i].s == 3'd4 || !vt[i].r)
        chk($sformatf("v%0d winner", i),   winner,     vt[i].w);
    end

    // Four paddle hits in PLAY, then watch the step cadence
    drive(0,0,0,0,0,0);
    drive(1,0,1,0,0,0);
    drive(1,1,0,0,0,0);
    drive(1,1,0,0,0,0);
    drive(1,0,0,0,0,0);
    chk("speed play", state, 2);
    for (int k = 0; k < 4; k++) drive(1,0,0,0,0,1);
`ifdef SPEEDUP_EN
    for (int k = 0; k < 3; k++) begin
      drive(1,1,0,0,0,0);
      chk($sformatf("fast tick%0d move_en", k), move_en, 1);
    end
    drive(1,0,0,0,1,0);
    drive(1,0,0,0,0,0);
    chk("speed point", state, 3);
    drive(1,1,0,0,0,0);
    drive(1,1,0,0,0,0);
    drive(1,1,0,0,0,0);
    chk("slow tick0 move_en", move_en, 0);
    drive(1,1,0,0,0,0);
    chk("slow tick1 move_en", move_en, 1);
`else
    drive(1,1,0,0,0,0);
    chk("fixed tick0 move_en", move_en, 0);
    drive(1,1,0,0,0,0);
    chk("fixed tick1 move_en", move_en, 1);
    drive(1,1,0,0,0,0);
    chk("fixed tick2 move_en", move_en, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
